key_filter: RTL and testbench

- Upstream input stage for the traffic light controller.
- Synchronises and debounces four raw active-low pushbuttons.
- Drives clean active-low levels onto the controller's rst1..rst4 inputs and provides single-cycle press/release pulses.
- Sits between board pins and the controller; runs on the same 50 MHz clock.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/key_debounce_one.sv | 179 +++++++++++++++++
 rtl/key_filter.sv | 46 ++++
 tb/tb_key_filter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared constants and types for the traffic light controller and its input
// stage (key_filter).
//   CLK_FREQ_HZ          system clock frequency (50 MHz)
//   DEFAULT_DEBOUNCE_CYC stable cycles needed to accept a new key level (20 ms)
//   DEFAULT_LONG_CYC     held-press duration for a long-press pulse (1 s)
//   key_state_e          per-key debounce state, KEY_UP = 0, KEY_DOWN = 1
//   cnt_width()          counter width needed to hold values up to max_cyc-1
package traffic_pkg;

  localparam int CLK_FREQ_HZ          = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYC = 1_000_000;
  localparam int DEFAULT_LONG_CYC     = 50_000_000;

  typedef enum logic {
    KEY_UP   = 1'b0,
    KEY_DOWN = 1'b1
  } key_state_e;

  // A counter that must reach max_cyc-1 needs $clog2(max_cyc) bits; never
  // return zero so a degenerate configuration still elaborates.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_one.sv
// key_debounce_one
// One pushbutton: 2-flop synchroniser, two-state debounce FSM with a single
// counter, and registered one-cycle press/release (and optional long-press)
// pulses.
// Optional feature macro: KEY_FILTER_LONGPRESS_EN (long-press pulse).
// Ports:
//   clk_50m      in   system clock
//   rst          in   asynchronous reset, active-low
//   key_raw      in   raw pin, active-low, asynchronous to clk_50m
//   key_level    out  debounced level, active-low (registered)
//   key_press    out  one-cycle pulse when the level is accepted as 1->0
//   key_release  out  one-cycle pulse when the level is accepted as 0->1
//   key_long     out  one-cycle pulse after a long hold; 0 without the macro
module key_debounce_one
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEFAULT_LONG_CYC
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

`ifdef KEY_FILTER_LONGPRESS_EN
  localparam int CNT_MAX = (LONG_CYC > DEBOUNCE_CYC) ? LONG_CYC : DEBOUNCE_CYC;
`else
  localparam int CNT_MAX = DEBOUNCE_CYC;
`endif
  localparam int               CNT_W    = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_FILTER_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`endif

  // Reject configurations the counter scheme cannot honour.
  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_cfg
    $error("key_debounce_one: need DEBOUNCE_CYC >= 2 and LONG_CYC > DEBOUNCE_CYC");
  end

  logic             sync_meta;
  logic             sync_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
`ifdef KEY_FILTER_LONGPRESS_EN
  logic             long_q, long_d;
  logic             long_done_q, long_done_d;
  logic             rel_phase_q, rel_phase_d;
`endif

  // Two-stage synchroniser; idles at 1 (released) so reset never looks like
  // a press.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= key_raw;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state_q     <= KEY_UP;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_FILTER_LONGPRESS_EN
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
      rel_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef KEY_FILTER_LONGPRESS_EN
      long_q      <= long_d;
      long_done_q <= long_done_d;
      rel_phase_q <= rel_phase_d;
`endif
    end
  end

  // The counter counts consecutive samples that disagree with the current
  // level; any agreeing sample clears it, and a state change clears it too,
  // so it can never run past DEB_LAST in the plain build.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_FILTER_LONGPRESS_EN
    long_d      = 1'b0;
    long_done_d = long_done_q;
    rel_phase_d = rel_phase_q;
`endif
    case (state_q)
      KEY_UP: begin
`ifdef KEY_FILTER_LONGPRESS_EN
        long_done_d = 1'b0;
        rel_phase_d = 1'b0;
`endif
        if (sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = KEY_DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KEY_DOWN: begin
`ifdef KEY_FILTER_LONGPRESS_EN
        // While held the counter measures hold time and parks at LONG_LAST.
        // The first released sample restarts it as a debounce count of one,
        // so release latency does not depend on how long the key was held.
        if (!sync_q) begin
          rel_phase_d = 1'b0;
          if (rel_phase_q) begin
            cnt_d = '0;
          end else if (cnt_q == LONG_LAST) begin
            if (!long_done_q) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          rel_phase_d = 1'b1;
          if (!rel_phase_q) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q == DEB_LAST) begin
            state_d   = KEY_UP;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        if (!sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = KEY_UP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = KEY_UP;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level   = (state_q == KEY_UP);
  assign key_press   = press_q;
  assign key_release = release_q;
`ifdef KEY_FILTER_LONGPRESS_EN
  assign key_long    = long_q;
`else
  assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// key_filter
// Input stage for the traffic light controller: synchronises and debounces
// KEY_NUM active-low pushbuttons independently. key_level[i] drives the
// controller's rst(i+1) input.
// Optional feature macro: KEY_FILTER_LONGPRESS_EN (long-press pulse).
// Ports:
//   clk_50m      in   system clock, 50 MHz
//   rst          in   asynchronous reset, active-low
//   key_raw      in   [KEY_NUM] raw pins, active-low
//   key_level    out  [KEY_NUM] debounced levels, active-low
//   key_press    out  [KEY_NUM] one-cycle pulse on accepted press
//   key_release  out  [KEY_NUM] one-cycle pulse on accepted release
//   key_long     out  [KEY_NUM] one-cycle long-press pulse (0 without macro)
module key_filter
  import traffic_pkg::*;
#(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEFAULT_LONG_CYC
) (
  input  logic               clk_50m,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_raw,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  // Keys share nothing, so simultaneous events give simultaneous pulses.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_key (
      .clk_50m    (clk_50m),
      .rst        (rst),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter
// Bench for key_filter with DEBOUNCE_CYC=16, LONG_CYC=64. A reference model
// accepts a new level after 16 consecutive disagreeing samples taken two
// clocks late; a compare process checks every output on every falling edge,
// and directed scenarios pin latencies with literal expectations.
module tb_key_filter;

  localparam int NK   = 4;
  localparam int DEB  = 16;
  localparam int LONG = 64;
`ifdef KEY_FILTER_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk_50m = 1'b0;
  logic          rst     = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int checks   = 0;
  int failures = 0;

  key_filter #(
    .KEY_NUM     (NK),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 clk_50m = ~clk_50m;

  // Reference model: what the outputs must be after each rising edge.
  logic [NK-1:0] m_level   = '1;
  logic [NK-1:0] m_press   = '0;
  logic [NK-1:0] m_release = '0;
  logic [NK-1:0] m_long    = '0;
  logic [NK-1:0] pipe1     = '1;
  logic [NK-1:0] pipe2     = '1;
  logic [NK-1:0] prev_seen = '1;
  logic [NK-1:0] seen;
  int            run  [NK];
  int            held [NK];
  bit            done [NK];

  always begin
    @(posedge clk_50m or negedge rst);
    if (!rst) begin
      pipe1 = '1; pipe2 = '1; prev_seen = '1;
      m_level = '1; m_press = '0; m_release = '0; m_long = '0;
      for (int i = 0; i < NK; i++) begin
        run[i] = 0; held[i] = 0; done[i] = 1'b0;
      end
    end else begin
      seen  = pipe2;
      pipe2 = pipe1;
      pipe1 = key_raw;
      m_press = '0; m_release = '0; m_long = '0;
      for (int i = 0; i < NK; i++) begin
        if (seen[i] != m_level[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (!m_level[i] && !seen[i]) begin
          if (prev_seen[i]) held[i] = 0;
          else held[i] = held[i] + 1;
          if (LONG_EN && held[i] >= LONG && !done[i]) begin
            m_long[i] = 1'b1;
            done[i]   = 1'b1;
          end
        end
        if (run[i] == DEB) begin
          if (m_level[i]) m_press[i] = 1'b1;
          else m_release[i] = 1'b1;
          m_level[i] = ~m_level[i];
          run[i] = 0; held[i] = 0; done[i] = 1'b0;
        end
        prev_seen[i] = seen[i];
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, actual, expected);
    end
  endtask

  // Single compare process: every cycle, DUT against model.
  always begin
    @(negedge clk_50m);
    checkOutput("key_level",   int'(key_level),   int'(m_level));
    checkOutput("key_press",   int'(key_press),   int'(m_press));
    checkOutput("key_release", int'(key_release), int'(m_release));
    checkOutput("key_long",    int'(key_long),    int'(m_long));
  end

  task automatic applyStimulus(input logic [NK-1:0] raw);
    key_raw = raw;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  // Count rising edges until a selected pulse appears on any masked bit.
  // sel: 0 press, 1 release, 2 long. Returns limit+1 on timeout.
  task automatic edges_until(input int sel, input logic [NK-1:0] mask,
                             input int limit, output int n);
    logic [NK-1:0] v;
    n = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk_50m);
      #1;
      v = (sel == 0) ? key_press : (sel == 1) ? key_release : key_long;
      if ((v & mask) != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic count_long(input int bit_idx, input int n_edges, output int pulses);
    pulses = 0;
    for (int k = 0; k < n_edges; k++) begin
      @(posedge clk_50m);
      #1;
      if (key_long[bit_idx]) pulses = pulses + 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    logic activity;

    $display("[TB] start");
    wait_edges(5);
    checkOutput("reset_level", int'(key_level), 15);
    checkOutput("reset_pulses", int'(key_press | key_release | key_long), 0);
    rst = 1'b1;
    wait_edges(4);
    checkOutput("idle_level", int'(key_level), 15);

    // Single press/release on key 0.
    applyStimulus(4'b1110);
    edges_until(0, 4'b0001, 40, n);
    checkOutput("press0_latency", n, 18);
    checkOutput("press0_level_same_cycle", int'(key_level), 4'b1110);
    wait_edges(5);
    applyStimulus(4'b1111);
    edges_until(1, 4'b0001, 40, n);
    checkOutput("release0_latency", n, 18);
    checkOutput("release0_level_same_cycle", int'(key_level), 4'b1111);
    wait_edges(5);

    // Key 1 bounces low 5 / high 5 for 200 cycles: never accepted.
    activity = 1'b0;
    for (int c = 0; c < 200; c++) begin
      applyStimulus({2'b11, ((c % 10) < 5) ? 1'b0 : 1'b1, 1'b1});
      wait_edges(1);
      activity = activity | key_press[1] | key_release[1] | ~key_level[1];
    end
    applyStimulus(4'b1111);
    checkOutput("glitch1_no_activity", int'(activity), 0);
    wait_edges(20);

    // Keys 2 and 3 together.
    applyStimulus(4'b0011);
    edges_until(0, 4'b1100, 40, n);
    checkOutput("press23_latency", n, 18);
    checkOutput("press23_both", int'(key_press & 4'b1100), 4'b1100);
    wait_edges(100 - n);
    applyStimulus(4'b1111);
    edges_until(1, 4'b1100, 40, n);
    checkOutput("release23_latency", n, 18);
    checkOutput("release23_both", int'(key_release & 4'b1100), 4'b1100);
    wait_edges(5);

    // Reset while key 0 is accepted as down: level returns at once.
    applyStimulus(4'b1110);
    edges_until(0, 4'b0001, 40, n);
    checkOutput("press0b_latency", n, 18);
    wait_edges(10);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_level", int'(key_level), 15);
    wait_edges(3);
    rst = 1'b1;
    edges_until(0, 4'b0001, 40, n);
    checkOutput("press_after_reset_held", n, 18);

    // Reset in the middle of a debounce count.
    applyStimulus(4'b1111);
    edges_until(1, 4'b0001, 40, n);
    checkOutput("release0b_latency", n, 18);
    wait_edges(10);
    applyStimulus(4'b1110);
    wait_edges(10);
    rst = 1'b0;
    #1;
    checkOutput("mid_debounce_reset_level", int'(key_level), 15);
    checkOutput("mid_debounce_reset_pulses", int'(key_press | key_release | key_long), 0);
    wait_edges(3);
    rst = 1'b1;
    edges_until(0, 4'b0001, 40, n);
    checkOutput("press_after_mid_reset", n, 18);

    // Long hold on key 0.
`ifdef KEY_FILTER_LONGPRESS_EN
    edges_until(2, 4'b0001, 100, n);
    checkOutput("long0_latency", n, LONG);
    count_long(0, 100, pulses);
    checkOutput("long0_no_repeat", pulses, 0);
`else
    count_long(0, 200, pulses);
    checkOutput("long0_absent", pulses, 0);
`endif
    applyStimulus(4'b1111);
    edges_until(1, 4'b0001, 40, n);
    checkOutput("release_after_long", n, 18);
    wait_edges(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
